// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth radix-2 multiply scheduler.
// Holds the FSM state encoding, default operand width and the Booth decode pairs.
package booth_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // {q0, q-1} pairs that require a datapath strobe.
    localparam logic [1:0] BOOTH_SUB = 2'b10;
    localparam logic [1:0] BOOTH_ADD = 2'b01;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/booth_rr_arb.sv
// Two-way round-robin arbiter: the pointer remembers the last winner, so on
// contention the other requester is granted. A lone requester always wins.
module booth_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic ptr_q;
    logic win;

    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~ptr_q;
            default: win = 1'b0;
        endcase
        gnt = 2'b00;
        if (grant_en && (|req)) begin
            gnt[win] = 1'b1;
        end
        gnt_id = win;
    end

    // Reset value 1 lets requester 0 win the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else if (grant_en && (|req)) begin
            ptr_q <= win;
        end
    end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Sequencer for the shared Booth radix-2 datapath: arbitrates two requesters,
// steps WIDTH evaluate/shift iterations and returns the 2*WIDTH-bit product.
module booth_mul_scheduler
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    input  logic [2*WIDTH-1:0] req_m,
    input  logic [2*WIDTH-1:0] req_q,
    output logic [1:0]         req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic               rsp_id,
    output logic               busy,
    output logic               dp_load,
    output logic [2*WIDTH-1:0] dp_operands,
    output logic               dp_add_valid,
    output logic               dp_add,
    output logic               dp_shift,
    input  logic [WIDTH:0]     dp_a,
    input  logic [WIDTH-1:0]   dp_q,
    input  logic               dp_qm1
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic             id_q;
    logic             load_q;
    logic             shift_q;
    logic             rsp_valid_q;
    logic             busy_q;

    logic [1:0] gnt;
    logic       gnt_id;
    logic       grant_en;
    logic [1:0] booth_bits;
    logic       unused_a_msb;

    // Grants are suppressed while reset is asserted so no request is lost.
    assign grant_en = (state_q == ST_IDLE) && !rst;

    booth_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .grant_en (grant_en),
        .gnt      (gnt),
        .gnt_id   (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            m_q         <= '0;
            q_q         <= '0;
            id_q        <= 1'b0;
            load_q      <= 1'b0;
            shift_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        m_q     <= gnt_id ? req_m[2*WIDTH-1:WIDTH] : req_m[WIDTH-1:0];
                        q_q     <= gnt_id ? req_q[2*WIDTH-1:WIDTH] : req_q[WIDTH-1:0];
                        id_q    <= gnt_id;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    shift_q <= 1'b1;
                    state_q <= ST_EVAL;
                end
                ST_EVAL: begin
                    shift_q <= 1'b1;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_EVAL;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // The shift strobe is registered, so it is raised when leaving EVAL only.
            if (state_q == ST_LOAD) begin
                shift_q <= 1'b0;
            end
        end
    end

    // Add/subtract must see the live datapath bits, so it is decoded in EVAL.
    assign booth_bits   = {dp_q[0], dp_qm1};
    assign dp_add_valid = (state_q == ST_EVAL) &&
                          ((booth_bits == BOOTH_SUB) || (booth_bits == BOOTH_ADD));
    assign dp_add       = (state_q == ST_EVAL) && (booth_bits == BOOTH_ADD);

    assign req_ready    = gnt;
    assign dp_load      = load_q;
    assign dp_shift     = shift_q;
    assign dp_operands  = {m_q, q_q};
    assign busy         = busy_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_valid_q & id_q;
    assign rsp_product  = rsp_valid_q ? {dp_a[WIDTH-1:0], dp_q} : '0;

    // A's extra bit only guards the subtract against overflow.
    assign unused_a_msb = dp_a[WIDTH];

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Bench for booth_mul_scheduler with a behavioural Booth datapath attached.
// Scenario tasks drive requests; a scoreboard pops expected {id, product} on each response.
module tb_booth_mul_scheduler;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [1:0]     req_valid;
    logic [2*W-1:0] req_m;
    logic [2*W-1:0] req_q;
    logic [1:0]     req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_product;
    logic           rsp_id;
    logic           busy;
    logic           dp_load;
    logic [2*W-1:0] dp_operands;
    logic           dp_add_valid;
    logic           dp_add;
    logic           dp_shift;
    logic [W:0]     dp_a;
    logic [W-1:0]   dp_q;
    logic           dp_qm1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int shift_cnt = 0;

    logic [31:0] stim_q0[$];
    logic [31:0] stim_q1[$];
    logic [16:0] exp_q[$];
    int          grant_log[$];
    logic [1:0]  hold;
    logic [31:0] cur0;
    logic [31:0] cur1;

    booth_mul_scheduler #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_m        (req_m),
        .req_q        (req_q),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_product  (rsp_product),
        .rsp_id       (rsp_id),
        .busy         (busy),
        .dp_load      (dp_load),
        .dp_operands  (dp_operands),
        .dp_add_valid (dp_add_valid),
        .dp_add       (dp_add),
        .dp_shift     (dp_shift),
        .dp_a         (dp_a),
        .dp_q         (dp_q),
        .dp_qm1       (dp_qm1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- Booth datapath model ----------------
    logic [W-1:0] m_r;
    initial begin
        dp_a = '0; dp_q = '0; dp_qm1 = 1'b0; m_r = '0;
    end
    always @(posedge clk) begin
        if (dp_load) begin
            dp_a   <= '0;
            dp_q   <= dp_operands[W-1:0];
            m_r    <= dp_operands[2*W-1:W];
            dp_qm1 <= 1'b0;
        end else if (dp_add_valid) begin
            dp_a <= dp_add ? dp_a + {m_r[W-1], m_r} : dp_a - {m_r[W-1], m_r};
        end else if (dp_shift) begin
            {dp_a, dp_q, dp_qm1} <= {dp_a[W], dp_a, dp_q};
        end
    end

    function automatic logic [15:0] golden(input logic [7:0] m, input logic [7:0] q);
        int a;
        int b;
        a = $signed(m);
        b = $signed(q);
        return 16'(a * b);
    endfunction

    // ---------------- requester drivers ----------------
    initial begin
        req_valid = 2'b00; req_m = '0; req_q = '0; hold = 2'b00; cur0 = '0; cur1 = '0;
        forever begin
            @(negedge clk);
            if (!hold[0] && stim_q0.size() > 0) begin cur0 = stim_q0.pop_front(); hold[0] = 1'b1; end
            if (!hold[1] && stim_q1.size() > 0) begin cur1 = stim_q1.pop_front(); hold[1] = 1'b1; end
            req_valid = hold;
            req_m = {cur1[31:24], cur0[31:24]};
            req_q = {cur1[23:16], cur0[23:16]};
            #1;
            checks++;
            if (((req_ready & ~req_valid) != 2'b00) || (req_ready == 2'b11)) begin
                errors++;
                $display("FAIL req_ready_onehot: ready=%b valid=%b", req_ready, req_valid);
            end
            if (hold[0] && req_ready[0]) begin
                exp_q.push_back({1'b0, cur0[15:0]}); grant_log.push_back(0);
                accept_cyc = cyc; hold[0] = 1'b0;
            end else if (hold[1] && req_ready[1]) begin
                exp_q.push_back({1'b1, cur1[15:0]}); grant_log.push_back(1);
                accept_cyc = cyc; hold[1] = 1'b0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic        rv_prev;
        logic [16:0] e;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                checks++;
                if ((int'(dp_load) + int'(dp_add_valid) + int'(dp_shift)) > 1) begin
                    errors++;
                    $display("FAIL strobe_excl: load=%b add=%b shift=%b", dp_load, dp_add_valid, dp_shift);
                end
                if (dp_load) shift_cnt = 0;
                if (dp_shift) shift_cnt++;
                if (rsp_valid && !rv_prev) begin
                    checks += 2;
                    if (cyc - accept_cyc != 2*W + 2) begin
                        errors++;
                        $display("FAIL latency: got %0d need %0d", cyc - accept_cyc, 2*W + 2);
                    end
                    if (shift_cnt != W) begin
                        errors++;
                        $display("FAIL shift_count: got %0d need %0d", shift_cnt, W);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp: id=%0d product=%h", rsp_id, rsp_product);
                    end else begin
                        e = exp_q.pop_front();
                        if ({rsp_id, rsp_product} !== e) begin
                            errors++;
                            $display("FAIL rsp: got id=%0d product=%h need id=%0d product=%h",
                                     rsp_id, rsp_product, e[16], e[15:0]);
                        end
                    end
                end
            end
            rv_prev = rsp_valid;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input int budget, input bit rand_ready);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
            #3;
            if (stim_q0.size() == 0 && stim_q1.size() == 0 && hold == 2'b00 &&
                exp_q.size() == 0 && !busy) break;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL wait_idle_timeout: pending=%0d need 0", exp_q.size());
        end
        rsp_ready = 1'b1;
    endtask

    task automatic wait_rsp(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #3;
            if (rsp_valid) break;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL wait_rsp_timeout: rsp_valid=%b need 1", rsp_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checks += 4;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_handshake: ready=%b rsp_valid=%b need 00/0", req_ready, rsp_valid);
        end
        if (rsp_product !== 16'h0000 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: product=%h id=%b need 0", rsp_product, rsp_id);
        end
        if ({busy, dp_load, dp_add_valid, dp_add, dp_shift} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: %b need 00000", {busy, dp_load, dp_add_valid, dp_add, dp_shift});
        end
        if (dp_operands !== 16'h0000) begin
            errors++; $display("FAIL reset_operands: %h need 0000", dp_operands);
        end
    endtask

    task automatic test_contention();
        grant_log.delete();
        stim_q0.push_back({8'd2,   8'd3,   16'h0006});
        stim_q0.push_back({8'hFC,  8'd5,   16'hFFEC});
        stim_q0.push_back({8'd10,  8'd10,  16'h0064});
        stim_q1.push_back({8'd7,   8'hFF,  16'hFFF9});
        stim_q1.push_back({8'd15,  8'd15,  16'h00E1});
        stim_q1.push_back({8'hF7,  8'd4,   16'hFFDC});
        @(negedge clk);
        rsp_ready = 1'b1;
        rst = 1'b0;
        wait_idle(400, 1'b0);
        checks++;
        if (grant_log.size() != 6) begin
            errors++; $display("FAIL contention_count: got %0d grants need 6", grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (grant_log[i] != (i % 2)) begin
                    errors++; $display("FAIL contention_order[%0d]: got %0d need %0d", i, grant_log[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_single();
        stim_q0.push_back({8'd3, 8'hFB, 16'hFFF1});
        rsp_ready = 1'b1;
        wait_rsp(60);
        checks++;
        if (rsp_product !== 16'hFFF1 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL single: product=%h id=%b need FFF1 id 0", rsp_product, rsp_id);
        end
        wait_idle(60, 1'b0);
    endtask

    task automatic test_corners();
        stim_q0.push_back({8'h80, 8'h80, 16'h4000});
        stim_q1.push_back({8'h7F, 8'h80, 16'hC080});
        wait_idle(100, 1'b0);
        stim_q0.push_back({8'h00, 8'hFF, 16'h0000});
        wait_idle(60, 1'b0);
        stim_q1.push_back({8'hFF, 8'hFF, 16'h0001});
        wait_idle(60, 1'b0);
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        stim_q1.push_back({8'd12, 8'hF9, 16'hFFAC});
        @(negedge clk);
        @(negedge clk);
        stim_q0.push_back({8'd9, 8'd9, 16'h0051});
        wait_rsp(60);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_product !== 16'hFFAC || rsp_id !== 1'b1 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b product=%h id=%b ready=%b need 1/FFAC/1/00",
                         i, rsp_valid, rsp_product, rsp_id, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #3;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL backpressure_handshake_ready: %b need 00", req_ready);
        end
        @(negedge clk);
        #3;
        checks++;
        if (req_ready !== 2'b01 || busy !== 1'b0) begin
            errors++; $display("FAIL backpressure_regrant: ready=%b busy=%b need 01/0", req_ready, busy);
        end
        wait_idle(60, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        int  n;
        bit  seen;
        n = 0;
        rsp_ready = 1'b1;
        stim_q0.push_back({8'd7, 8'd9, 16'h003F});
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            #3;
            if (dp_shift) n++;
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL midop_shift_wait: got %0d shifts need 4", n);
        end
        rst = 1'b1;
        @(negedge clk);
        #3;
        checks++;
        if ({dp_load, dp_add_valid, dp_shift, busy, rsp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL midop_abort: load/add/shift/busy/rsp=%b need 00000",
                     {dp_load, dp_add_valid, dp_shift, busy, rsp_valid});
        end
        exp_q.delete();
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            #3;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL midop_no_rsp: rsp_valid seen=1 need 0");
        end
        stim_q0.push_back({8'd5, 8'd6, 16'h001E});
        wait_rsp(60);
        checks++;
        if (rsp_product !== 16'h001E) begin
            errors++; $display("FAIL midop_fresh: product=%h need 001E", rsp_product);
        end
        wait_idle(60, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] m;
        logic [7:0] q;
        for (int i = 0; i < 500; i++) begin
            m = 8'($urandom_range(0, 255));
            q = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) stim_q0.push_back({m, q, golden(m, q)});
            else                           stim_q1.push_back({m, q, golden(m, q)});
        end
        wait_idle(40000, 1'b1);
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_corners();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mul_scheduler.md
# booth_mul_scheduler

Sequencer and two-port arbiter for the shared Booth radix-2 datapath. Two requesters submit signed operand pairs over valid/ready; a round-robin arbiter grants one. The block loads the datapath and drives the add/subtract and shift strobes for WIDTH iterations, then returns the signed 2·WIDTH-bit product with the winner's ID. It replaces button-stepped sequencing wherever the multiplier is used as a compute resource.

## Interface
- WIDTH, 8, operand width in bits; the product is 2·WIDTH bits.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_m  in  2·WIDTH  multiplicands; requester i occupies slice [i·WIDTH +: WIDTH], signed.
- req_q  in  2·WIDTH  multipliers, same slicing as req_m, signed.
- req_ready  out  2  one-hot accept pulse; the handshake completes when req_valid[i] & req_ready[i].
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_product  out  2·WIDTH  signed product.
- rsp_id  out  1  index of the requester that owns rsp_product.
- busy  out  1  high in every state except IDLE.
- dp_load  out  1  datapath load strobe: captures dp_operands, clears A and q₋₁.
- dp_operands  out  2·WIDTH  {M, Q} presented to the datapath.
- dp_add_valid  out  1  perform an add/subtract this cycle.
- dp_add  out  1  1: A ← A + M; 0: A ← A − M (qualified by dp_add_valid).
- dp_shift  out  1  arithmetic right shift of {A, Q, q₋₁}.
- dp_a  in  WIDTH+1  datapath A register.
- dp_q  in  WIDTH  datapath Q register.
- dp_qm1  in  1  datapath q₋₁ bit.

## Operation
- **States:** IDLE, LOAD, EVAL, SHIFT, DONE.
- **IDLE:** if any req_valid bit is set, the arbiter picks a winner and req_ready[winner] is driven high combinationally in this cycle.
  - The winner's operands and ID are latched.
  - Next state is LOAD.
- **Round-robin:** a priority pointer holds the index of the last granted requester. On contention the other requester wins. With a single requester, that requester wins regardless of the pointer. The pointer updates only on grant.
- **LOAD:** assert dp_load with dp_operands = {latched M, latched Q}; clear the iteration counter. Next state is EVAL.
- **EVAL:** decode {dp_q[0], dp_qm1}:
  - 10: dp_add_valid = 1, dp_add = 0 (subtract).
  - 01: dp_add_valid = 1, dp_add = 1 (add).
  - 00 or 11: no strobe.
  - Next state is SHIFT.
- **SHIFT:** assert dp_shift and increment the counter. When the counter reaches WIDTH, next state is DONE; otherwise EVAL.
- **DONE:**
  - rsp_valid = 1, rsp_product = {dp_a[WIDTH−1:0], dp_q}, rsp_id = latched ID.
  - All dp_* strobes stay low, so the datapath holds.
  - On rsp_valid & rsp_ready, go to IDLE.
- **Strobe exclusivity:** at most one of dp_load, dp_add_valid, dp_shift is high in any cycle.
- **Width rule:** A is WIDTH+1 bits, so subtracting the most negative M cannot overflow. The result fits in 2·WIDTH bits for all operand pairs, including min × min.
- **Requester rules:** a requester holds req_valid and its operands stable until it sees ready. A requester not granted in a cycle sees req_ready = 0 and keeps waiting.

## Timing
- **Reset values:** state = IDLE, pointer = 1 (requester 0 wins the first contention), counter = 0. All outputs are 0: req_ready, rsp_valid, rsp_product, rsp_id, busy, dp_load, dp_add_valid, dp_add, dp_shift, dp_operands.
- **Reset mid-operation:** abandon the current operation. Strobes go low in the cycle after rst is sampled. No response is produced for the aborted request.
- **Latency:** the accept cycle is t0; LOAD is t0+1; EVAL/SHIFT pairs run t0+2 … t0+2·WIDTH+1; rsp_valid first rises at t0+2·WIDTH+2 (t0+18 for WIDTH = 8).
- **Response hold:** rsp_valid stays high, with rsp_product and rsp_id stable, until rsp_ready is sampled high. If rsp_ready is already high on the first DONE cycle, the response lasts exactly one cycle.
- **Return to IDLE:** the FSM enters IDLE the cycle after the response handshake. The earliest next req_ready is that IDLE cycle, so throughput is one product per 2·WIDTH+3 cycles.
- **While busy:** req_ready = 00 in all non-IDLE states; pending requests simply wait.

## Structure
- **Package booth_pkg:**
  - state enum (IDLE, LOAD, EVAL, SHIFT, DONE);
  - default WIDTH localparam;
  - counter width $clog2(WIDTH+1);
  - Booth decode constants for 10 (subtract) and 01 (add).
- **Sub-module booth_rr_arb:** 2-way round-robin arbiter. Inputs: req[1:0], grant_en, clk, rst. Outputs: one-hot gnt[1:0], gnt_id. The pointer updates when grant_en & |req.
- **booth_mul_scheduler:** contains the FSM, operand/ID latches and the iteration counter, and connects to the existing Booth datapath.

## Test plan
- **Single product:** req0 sends 3 × −5. Expect rsp_product = 0xFFF1 (−15), rsp_id = 0, rsp_valid at accept+18. Monitor checks that strobes are exclusive and dp_shift pulses exactly 8 times.
- **Corner products:** −128 × −128 → 0x4000; 127 × −128 → 0xC080; 0 × −1 → 0x0000; −1 × −1 → 0x0001.
- **Contention:** req0 and req1 valid together from reset, rsp_ready tied high. Grants go req0, req1, req0, … with correct IDs. A request held continuously is never starved.
- **Response backpressure:** rsp_ready low for 10 cycles after rsp_valid. Product and ID stay stable, req_ready stays 00, and a new grant occurs only in the IDLE cycle after the handshake.
- **Reset mid-operation:** assert rst during the 4th SHIFT. Next cycle all strobes are 0 and busy = 0; no response appears. A fresh request 5 × 6 then returns 0x001E.
- **Random compare:** 500 random signed operand pairs from both requesters with random rsp_ready, checked against a golden multiply. Each response ID matches its request order per requester.
